mult_hilo_unit: RTL and testbench

- Multi-cycle integer multiplier with HI/LO result registers for the pipelined MIPS core.
- Consumes the main decoder's Start_mult/Mult_sign strobes from MULT/MULTU in EX, iterates shift-add, and writes the 2*WIDTH product into HI/LO.
- Serves MFHI/MFLO reads and raises a stall while a read hits an in-flight multiply.

---
 rtl/mult_hilo_unit_pkg.sv | 16 +
 rtl/mult_hilo_unit_if.sv | 27 ++
 rtl/mult_booth_step.sv | 25 ++
 rtl/mult_hilo_unit.sv | 128 ++++++++++++
 tb/tb_mult_hilo_unit.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_hilo_unit_pkg.sv
// Shared types and constants for the HI/LO multiplier unit and its decode interface.
package mult_pkg;

  localparam int MULT_WIDTH = 32;

  typedef enum logic {
    MULT_IDLE = 1'b0,
    MULT_RUN  = 1'b1
  } mult_state_t;

  // Out_select encodings used by the main decoder's writeback mux
  localparam logic [1:0] OUT_SEL_MFHI = 2'b11;
  localparam logic [1:0] OUT_SEL_MFLO = 2'b10;
  localparam logic [1:0] OUT_SEL_ALU  = 2'b00;

endpackage

// File: rtl/mult_hilo_unit_if.sv
// Decode/EX-side bundle for the multiplier: start strobes, operands, HI/LO read port and status.
interface mult_hilo_unit_if
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
);
  logic             Start_mult;
  logic             Mult_sign;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             Hilo_rd;
  logic             Hi_sel;
  logic [WIDTH-1:0] Hilo_out;
  logic             Busy;
  logic             Done;
  logic             Stall;

  modport master (
    output Start_mult, Mult_sign, SrcA, SrcB, Hilo_rd, Hi_sel,
    input  Hilo_out, Busy, Done, Stall
  );

  modport slave (
    input  Start_mult, Mult_sign, SrcA, SrcB, Hilo_rd, Hi_sel,
    output Hilo_out, Busy, Done, Stall
  );
endinterface

// File: rtl/mult_booth_step.sv
// One shift-add iteration: adds multiplicand * digit into the accumulator, RADIX_BITS bits at a time.
module mult_booth_step #(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 1
) (
  input  logic [2*WIDTH-1:0]    acc_in,
  input  logic [2*WIDTH-1:0]    mcand_in,
  input  logic [RADIX_BITS-1:0] digit,
  output logic [2*WIDTH-1:0]    acc_out
);

  // mcand_in is already aligned to this iteration's weight; each digit bit adds a further shift
  logic [2*WIDTH-1:0] pp_sum [RADIX_BITS+1];

  assign pp_sum[0] = acc_in;

  generate
    for (genvar gi = 0; gi < RADIX_BITS; gi++) begin : g_pp
      assign pp_sum[gi+1] = pp_sum[gi] + (digit[gi] ? (mcand_in << gi) : '0);
    end
  endgenerate

  assign acc_out = pp_sum[RADIX_BITS];

endmodule

// File: rtl/mult_hilo_unit.sv
// Multi-cycle shift-add multiplier with HI/LO result registers and MFHI/MFLO stall.
// Define MULT_EARLY_TERM_EN to commit as soon as the remaining multiplier bits are all zero.
module mult_hilo_unit
  import mult_pkg::*;
#(
  parameter int WIDTH      = MULT_WIDTH,
  parameter int RADIX_BITS = 1
) (
  input logic             clk,
  input logic             reset,
  mult_hilo_unit_if.slave bus
);

  localparam int N  = WIDTH / RADIX_BITS;
  localparam int CW = $clog2(N + 1);

  mult_state_t        state_reg, state_next;
  logic [2*WIDTH-1:0] acc_reg, acc_next;
  logic [2*WIDTH-1:0] mcand_reg, mcand_next;
  logic [WIDTH-1:0]   mplier_reg, mplier_next;
  logic [WIDTH-1:0]   hi_reg, hi_next;
  logic [WIDTH-1:0]   lo_reg, lo_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic               neg_reg, neg_next;
  logic               done_reg, done_next;

  logic [2*WIDTH-1:0] step_sum;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH-1:0]   mplier_shift;
  logic               last_step;

  mult_booth_step #(
    .WIDTH      (WIDTH),
    .RADIX_BITS (RADIX_BITS)
  ) u_step (
    .acc_in   (acc_reg),
    .mcand_in (mcand_reg),
    .digit    (mplier_reg[RADIX_BITS-1:0]),
    .acc_out  (step_sum)
  );

  // Magnitudes are kept as unsigned WIDTH values so the most negative operand stays exact
  assign mag_a = (bus.Mult_sign && bus.SrcA[WIDTH-1]) ? -bus.SrcA : bus.SrcA;
  assign mag_b = (bus.Mult_sign && bus.SrcB[WIDTH-1]) ? -bus.SrcB : bus.SrcB;

  assign mplier_shift = mplier_reg >> RADIX_BITS;
  assign product      = neg_reg ? -step_sum : step_sum;

`ifdef MULT_EARLY_TERM_EN
  assign last_step = (cnt_reg == CW'(1)) || (mplier_shift == '0);
`else
  assign last_step = (cnt_reg == CW'(1));
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= MULT_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    acc_next    = acc_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    cnt_next    = cnt_reg;
    neg_next    = neg_reg;
    done_next   = 1'b0;

    case (state_reg)
      MULT_IDLE: begin
        if (bus.Start_mult) begin
          mcand_next  = {{WIDTH{1'b0}}, mag_a};
          mplier_next = mag_b;
          neg_next    = bus.Mult_sign & (bus.SrcA[WIDTH-1] ^ bus.SrcB[WIDTH-1]);
          acc_next    = '0;
          cnt_next    = CW'(N);
          state_next  = MULT_RUN;
        end
      end
      MULT_RUN: begin
        acc_next    = step_sum;
        mcand_next  = mcand_reg << RADIX_BITS;
        mplier_next = mplier_shift;
        cnt_next    = cnt_reg - CW'(1);
        if (last_step) begin
          {hi_next, lo_next} = product;
          done_next          = 1'b1;
          state_next         = MULT_IDLE;
        end
      end
      default: state_next = MULT_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      cnt_reg    <= '0;
      neg_reg    <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
      cnt_reg    <= cnt_next;
      neg_reg    <= neg_next;
      done_reg   <= done_next;
    end
  end

  assign bus.Busy     = (state_reg == MULT_RUN);
  assign bus.Done     = done_reg;
  assign bus.Stall    = bus.Hilo_rd & bus.Busy;
  assign bus.Hilo_out = bus.Hi_sel ? hi_reg : lo_reg;

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Directed bench for mult_hilo_unit: arithmetic reference model plus hand-computed HI/LO and latency.
module tb_mult_hilo_unit;

  localparam int W     = 32;
  localparam int RADIX = 1;
`ifdef MULT_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;

  mult_hilo_unit_if #(.WIDTH(W)) bus ();

  mult_hilo_unit #(
    .WIDTH      (W),
    .RADIX_BITS (RADIX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Full-precision reference product from plain 64-bit arithmetic
  function automatic logic [63:0] ref_product(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic [63:0]        ua;
    logic [63:0]        ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    if (s) return sa * sb;
    return ua * ub;
  endfunction

  function automatic int ref_latency(input logic [31:0] b, input logic s);
    logic [31:0] m;
    int          msb;
    int          early_len;
    m   = (s && b[31]) ? -b : b;
    msb = -1;
    for (int i = 0; i < 32; i++) if (m[i]) msb = i;
    early_len = (msb < 0) ? 1 : (msb + RADIX) / RADIX;
    return EARLY ? early_len : (32 / RADIX);
  endfunction

  function automatic int exp_busy(input int dflt, input int early);
    return EARLY ? early : dflt;
  endfunction

  // Reference model: remaining busy cycles and committed {HI,LO}
  int          m_left = 0;
  logic [63:0] m_hilo = '0;
  logic [63:0] m_pend = '0;
  logic        m_done = 1'b0;
  logic [31:0] m_a, m_b;
  logic        m_s;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_left = 0;
      m_hilo = '0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_hilo = m_pend;
          m_done = 1'b1;
          $display("txn %s a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h",
                   m_s ? "MULT " : "MULTU", m_a, m_b, m_hilo[63:32], m_hilo[31:0]);
        end
      end else if (bus.Start_mult) begin
        m_a    = bus.SrcA;
        m_b    = bus.SrcB;
        m_s    = bus.Mult_sign;
        m_pend = ref_product(bus.SrcA, bus.SrcB, bus.Mult_sign);
        m_left = ref_latency(bus.SrcB, bus.Mult_sign);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("cyc_busy",  bus.Busy,  m_left > 0);
      check("cyc_done",  bus.Done,  m_done);
      check("cyc_stall", bus.Stall, bus.Hilo_rd && (m_left > 0));
      check("cyc_hilo",  bus.Hilo_out, bus.Hi_sel ? m_hilo[63:32] : m_hilo[31:0]);
    end
  end

  task automatic start_mult(input logic [31:0] a, input logic [31:0] b, input logic s);
    bus.Start_mult = 1'b1;
    bus.Mult_sign  = s;
    bus.SrcA       = a;
    bus.SrcB       = b;
    @(posedge clk);
    #1;
    bus.Start_mult = 1'b0;
  endtask

  // Returns at the falling edge inside the Done cycle
  task automatic run_to_done(input string name, output int busy_cycles);
    bit seen;
    seen        = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.Done) begin
        seen = 1'b1;
        break;
      end
      if (bus.Busy) busy_cycles++;
    end
    check({name, "_done_seen"}, seen, 1'b1);
  endtask

  task automatic check_hilo(input string name, input logic [31:0] hi, input logic [31:0] lo);
    bus.Hi_sel = 1'b1;
    #1;
    check({name, "_hi"}, bus.Hilo_out, hi);
    bus.Hi_sel = 1'b0;
    #1;
    check({name, "_lo"}, bus.Hilo_out, lo);
  endtask

  initial begin
    int bc;
    int sc;
    int dc;
    bus.Start_mult = 1'b0;
    bus.Mult_sign  = 1'b0;
    bus.SrcA       = '0;
    bus.SrcB       = '0;
    bus.Hilo_rd    = 1'b0;
    bus.Hi_sel     = 1'b0;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_busy", bus.Busy, 1'b0);
    check("rst_done", bus.Done, 1'b0);
    check_hilo("rst", 32'h0, 32'h0);

    // Unsigned all-ones
    @(posedge clk); #1;
    start_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_to_done("multu_ff", bc);
    check("multu_ff_busy", bc, exp_busy(32, 32));
    check_hilo("multu_ff", 32'hFFFF_FFFE, 32'h0000_0001);

    // Signed -3 * 5
    @(posedge clk); #1;
    start_mult(32'hFFFF_FFFD, 32'd5, 1'b1);
    run_to_done("mult_m3x5", bc);
    check("mult_m3x5_busy", bc, exp_busy(32, 3));
    check_hilo("mult_m3x5", 32'hFFFF_FFFF, 32'hFFFF_FFF1);

    // Signed 7 * -2
    @(posedge clk); #1;
    start_mult(32'd7, 32'hFFFF_FFFE, 1'b1);
    run_to_done("mult_7xm2", bc);
    check("mult_7xm2_busy", bc, exp_busy(32, 2));
    check_hilo("mult_7xm2", 32'hFFFF_FFFF, 32'hFFFF_FFF2);

    // Most negative operand squared
    @(posedge clk); #1;
    start_mult(32'h8000_0000, 32'h8000_0000, 1'b1);
    run_to_done("mult_min", bc);
    check("mult_min_busy", bc, exp_busy(32, 32));
    check_hilo("mult_min", 32'h4000_0000, 32'h0000_0000);

    // MFHI issued one instruction behind the MULTU
    @(posedge clk); #1;
    start_mult(32'd3, 32'h8000_0001, 1'b0);
    @(posedge clk); #1;
    bus.Hilo_rd = 1'b1;
    bus.Hi_sel  = 1'b1;
    sc = 0;
    bc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.Done) begin
        bc = 1;
        break;
      end
      if (bus.Stall) sc++;
    end
    check("stall_done_seen", bc, 1);
    check("stall_cycles", sc, 31);
    check("stall_in_done", bus.Stall, 1'b0);
    check("stall_new_hi", bus.Hilo_out, 32'h0000_0001);
    bus.Hilo_rd = 1'b0;
    check_hilo("stall", 32'h0000_0001, 32'h8000_0003);

    // Back-to-back: second start lands in the Done cycle
    @(posedge clk); #1;
    start_mult(32'h10, 32'h10, 1'b0);
    run_to_done("b2b_first", bc);
    check_hilo("b2b_first", 32'h0, 32'h100);
    start_mult(32'd7, 32'd6, 1'b0);
    run_to_done("b2b_second", bc);
    check("b2b_second_busy", bc, exp_busy(32, 3));
    check_hilo("b2b_second", 32'h0, 32'd42);

    // Start re-pulsed while busy must be ignored
    @(posedge clk); #1;
    start_mult(32'd9, 32'h8000_0009, 1'b0);
    repeat (EARLY ? 2 : 10) @(posedge clk);
    #1;
    $display("note: Start_mult re-pulsed while Busy (decode error); unit should ignore it");
    start_mult(32'hFFFF, 32'hFFFF, 1'b1);
    run_to_done("ignored", bc);
    check_hilo("ignored", 32'h0000_0004, 32'h8000_0051);
    repeat (3) @(negedge clk);
    check("ignored_idle", bus.Busy, 1'b0);
    check_hilo("ignored_hold", 32'h0000_0004, 32'h8000_0051);

    // Asynchronous reset in the middle of a multiply
    @(posedge clk); #1;
    start_mult(32'd2, 32'd3, 1'b1);
    repeat (EARLY ? 0 : 9) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_busy", bus.Busy, 1'b0);
    check("rst_mid_done", bus.Done, 1'b0);
    check_hilo("rst_mid", 32'h0, 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    dc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.Done) dc++;
    end
    check("rst_mid_no_done", dc, 0);
    check_hilo("rst_mid_after", 32'h0, 32'h0);

    // Short multipliers (single-cycle and two-cycle when terminating early)
    @(posedge clk); #1;
    start_mult(32'h1234_5678, 32'd3, 1'b0);
    run_to_done("short3", bc);
    check("short3_busy", bc, exp_busy(32, 2));
    check_hilo("short3", 32'h0, 32'h369D_0368);
    @(posedge clk); #1;
    start_mult(32'hDEAD_BEEF, 32'd0, 1'b1);
    run_to_done("zero", bc);
    check("zero_busy", bc, exp_busy(32, 1));
    check_hilo("zero", 32'h0, 32'h0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
